// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, coefficient types and default taps for the fir_axis filter.
package fir_pkg;

   localparam int NUM_TAPS = 16;
   localparam int SAMPLE_W = 16;
   localparam int COEF_W   = 16;
   localparam int PROD_W   = 32;
   localparam int ACC_W    = 36;

   typedef logic signed [COEF_W-1:0]   coef_t;
   typedef logic signed [SAMPLE_W-1:0] sample_t;
   typedef logic signed [PROD_W-1:0]   prod_t;
   typedef logic signed [ACC_W-1:0]    acc_t;
   typedef coef_t coef_arr_t [NUM_TAPS];

   // Moving average: sixteen taps of 1/16 in Q1.15.
   localparam coef_arr_t DEFAULT_COEFS = '{default: 16'sh0800};

endpackage

// File: rtl/fir_sat.sv
// fir_sat: combinational arithmetic right shift of the accumulator, saturated to OUT_W signed bits.
module fir_sat
   import fir_pkg::*;
#(
   parameter int SHIFT = 15,
   parameter int OUT_W = 32
) (
   input  acc_t                    acc,
   output logic signed [OUT_W-1:0] result
);

   acc_t shifted;

   // NOTE: every path through this block assigns both outputs, so no latch is inferred.
   always_comb begin
      shifted = acc >>> SHIFT;
      if ((&shifted[ACC_W-1:OUT_W-1]) || !(|shifted[ACC_W-1:OUT_W-1])) begin
         result = shifted[OUT_W-1:0];
      end else if (shifted[ACC_W-1]) begin
         result = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
         result = {1'b0, {(OUT_W-1){1'b1}}};
      end
   end

endmodule

// File: rtl/fir_axis.sv
// fir_axis: pipelined 16-tap FIR on an AXI-Stream sample stream (delay line, products, sum, output).
// Define FIR_FRAME_FLUSH_EN to clear the delay line after every tlast beat.
module fir_axis
   import fir_pkg::*;
#(
   parameter int        C_S00_AXIS_TDATA_WIDTH = 32,
   parameter int        C_M00_AXIS_TDATA_WIDTH = 32,
   parameter int        OUT_SHIFT              = 15,
   parameter coef_arr_t COEFS                  = DEFAULT_COEFS
) (
   input  logic                                  s00_axis_aclk,
   input  logic                                  s00_axis_aresetn,
   input  logic                                  s00_axis_tvalid,
   input  logic                                  s00_axis_tlast,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
   input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
   output logic                                  s00_axis_tready,
   input  logic                                  m00_axis_tready,
   output logic                                  m00_axis_tvalid,
   output logic                                  m00_axis_tlast,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
   output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb
);

   logic    en, accept, flush_pend;
   sample_t sample;
   sample_t taps [NUM_TAPS];
   prod_t   prod [NUM_TAPS];
   acc_t    sum_d, sum_q;
   logic    v0, l0, v1, l1, v2, l2;
   logic signed [C_M00_AXIS_TDATA_WIDTH-1:0] sat_result;
   logic    unused;

   assign en              = !m00_axis_tvalid || m00_axis_tready;
   assign s00_axis_tready = en;
   assign accept          = s00_axis_tvalid && en;
   assign sample          = sample_t'(s00_axis_tdata[SAMPLE_W-1:0]);
   assign m00_axis_tstrb  = '1;
   assign unused          = ^{s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:SAMPLE_W], s00_axis_tstrb};

`ifdef FIR_FRAME_FLUSH_EN
   // Flush waits for an enabled edge so a stalled last beat still reaches the product stage.
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         flush_pend <= 1'b0;
      end else if (en) begin
         flush_pend <= accept && s00_axis_tlast;
      end
   end
`else
   assign flush_pend = 1'b0;
`endif

   // NOTE: non-blocking (<=) so each stage samples the previous stage's value from before the edge.
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         for (int k = 0; k < NUM_TAPS; k++) taps[k] <= '0;
         v0 <= 1'b0;
         l0 <= 1'b0;
      end else if (en) begin
         v0 <= accept;
         l0 <= accept && s00_axis_tlast;
         if (accept) begin
            taps[0] <= sample;
            for (int k = 1; k < NUM_TAPS; k++) taps[k] <= flush_pend ? '0 : taps[k-1];
         end else if (flush_pend) begin
            for (int k = 0; k < NUM_TAPS; k++) taps[k] <= '0;
         end
      end
   end

   always_comb begin
      sum_d = '0;
      for (int k = 0; k < NUM_TAPS; k++) sum_d = sum_d + ACC_W'(prod[k]);
   end

   fir_sat #(
      .SHIFT (OUT_SHIFT),
      .OUT_W (C_M00_AXIS_TDATA_WIDTH)
   ) u_sat (
      .acc    (sum_q),
      .result (sat_result)
   );

   // NOTE: the whole datapath is reset, not just the valids, so the first output after reset sees zero history.
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         for (int k = 0; k < NUM_TAPS; k++) prod[k] <= '0;
         sum_q           <= '0;
         v1              <= 1'b0;
         l1              <= 1'b0;
         v2              <= 1'b0;
         l2              <= 1'b0;
         m00_axis_tvalid <= 1'b0;
         m00_axis_tlast  <= 1'b0;
         m00_axis_tdata  <= '0;
      end else if (en) begin
         for (int k = 0; k < NUM_TAPS; k++) prod[k] <= PROD_W'(taps[k]) * PROD_W'(COEFS[k]);
         v1              <= v0;
         l1              <= l0;
         sum_q           <= sum_d;
         v2              <= v1;
         l2              <= l1;
         m00_axis_tvalid <= v2;
         m00_axis_tlast  <= l2;
         m00_axis_tdata  <= sat_result;
      end
   end

endmodule

// File: tb/tb_fir_axis.sv
// tb_fir_axis: directed self-checking bench for fir_axis (three parameterisations share one stimulus stream).
module tb_fir_axis;
   import fir_pkg::*;

   localparam coef_arr_t SAT_COEFS = '{default: 16'sh7FFF};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_last = 1'b0;
   logic [31:0] s_data = '0;
   logic [3:0]  s_strb = '1;
   logic        m_ready = 1'b1;
   int          bp_mode = 0;

   logic        a_s_ready, a_valid, a_last;
   logic [31:0] a_data;
   logic [3:0]  a_strb;
   logic        b_s_ready, b_valid, b_last;
   logic [31:0] b_data;
   logic [3:0]  b_strb;
   logic        c_s_ready, c_valid, c_last;
   logic [31:0] c_data;
   logic [3:0]  c_strb;

   int passed = 0;
   int total  = 0;

   logic [31:0] qa[$];
   logic [31:0] qb[$];
   logic [31:0] qc[$];
   logic        ql[$];

   logic signed [15:0] xin [1024];

   always #5 clk = ~clk;

   fir_axis #(.OUT_SHIFT(0)) dut_a (
      .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
      .s00_axis_tvalid(s_valid), .s00_axis_tlast(s_last), .s00_axis_tdata(s_data),
      .s00_axis_tstrb(s_strb), .s00_axis_tready(a_s_ready), .m00_axis_tready(m_ready),
      .m00_axis_tvalid(a_valid), .m00_axis_tlast(a_last), .m00_axis_tdata(a_data),
      .m00_axis_tstrb(a_strb));

   fir_axis #(.OUT_SHIFT(15)) dut_b (
      .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
      .s00_axis_tvalid(s_valid), .s00_axis_tlast(s_last), .s00_axis_tdata(s_data),
      .s00_axis_tstrb(s_strb), .s00_axis_tready(b_s_ready), .m00_axis_tready(m_ready),
      .m00_axis_tvalid(b_valid), .m00_axis_tlast(b_last), .m00_axis_tdata(b_data),
      .m00_axis_tstrb(b_strb));

   fir_axis #(.OUT_SHIFT(0), .COEFS(SAT_COEFS)) dut_c (
      .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
      .s00_axis_tvalid(s_valid), .s00_axis_tlast(s_last), .s00_axis_tdata(s_data),
      .s00_axis_tstrb(s_strb), .s00_axis_tready(c_s_ready), .m00_axis_tready(m_ready),
      .m00_axis_tvalid(c_valid), .m00_axis_tlast(c_last), .m00_axis_tdata(c_data),
      .m00_axis_tstrb(c_strb));

   // Downstream ready: 0 = always ready, 1 = random 50%, 2 = held off.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         m_ready = (bp_mode == 0) ? 1'b1 : (bp_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   end

   // Record every output transfer of each instance.
   always @(negedge clk) begin
      if (rst_n && m_ready) begin
         if (a_valid) begin
            qa.push_back(a_data);
            ql.push_back(a_last);
         end
         if (b_valid) qb.push_back(b_data);
         if (c_valid) qc.push_back(c_data);
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: observed time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic send(input logic [15:0] d, input logic last);
      int n = 0;
      s_data  = {16'hDEAD, d};
      s_last  = last;
      s_valid = 1'b1;
      @(negedge clk);
      while (!a_s_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) begin
         total++;
         $error("FAIL send_timeout: observed %0d cycles, required < 1000", n);
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic drain(input int n);
      int c = 0;
      while (qa.size() < n && c < 20000) begin
         @(negedge clk);
         c++;
      end
      repeat (8) @(negedge clk);
      check("drain_count", 32'(qa.size()), 32'(n));
   endtask

   task automatic do_reset();
      bp_mode = 0;
      rst_n   = 1'b0;
      repeat (2) @(negedge clk);
      qa.delete();
      qb.delete();
      qc.delete();
      ql.delete();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      longint acc;
      logic [31:0] exp_v;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_tvalid", 32'(a_valid), 32'd0);
      check("rst_tlast", 32'(a_last), 32'd0);
      check("rst_tdata", a_data, 32'd0);
      check("rst_s_ready", 32'(a_s_ready), 32'd1);
      check("tstrb_ones", 32'(a_strb), 32'hF);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Impulse: 3-cycle latency, then 16 outputs of 2048
      send(16'd1, 1'b0);
      check("lat_n1", 32'(a_valid), 32'd0);
      @(posedge clk); #1;
      check("lat_n2", 32'(a_valid), 32'd0);
      @(posedge clk); #1;
      check("lat_n3_pre", 32'(a_valid), 32'd0);
      @(posedge clk); #1;
      check("lat_n3_valid", 32'(a_valid), 32'd1);
      check("lat_n3_data", a_data, 32'd2048);
      for (int i = 0; i < 20; i++) send(16'd0, 1'b0);
      drain(21);
      for (int i = 0; i < 21; i++) check($sformatf("impulse[%0d]", i), qa[i], (i < 16) ? 32'd2048 : 32'd0);

      // Stall holds output and drops s00_axis_tready
      do_reset();
      bp_mode = 2;
      send(16'd3, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         check("stall_valid", 32'(a_valid), 32'd1);
         check("stall_data", a_data, 32'd6144);
         check("stall_s_ready", 32'(a_s_ready), 32'd0);
         @(posedge clk); #1;
      end
      bp_mode = 0;

      // Step at OUT_SHIFT=15: 62, 125, 187, ... then 1000
      do_reset();
      for (int i = 0; i < 20; i++) send(16'd1000, 1'b0);
      drain(20);
      check("step_first", qb[0], 32'd62);
      check("step_second", qb[1], 32'd125);
      for (int i = 0; i < 20; i++)
         check($sformatf("step[%0d]", i), qb[i], (i < 15) ? 32'((i + 1) * 125 / 2) : 32'd1000);

      // Positive saturation with all-0x7FFF taps
      do_reset();
      for (int i = 0; i < 16; i++) send(16'h7FFF, 1'b0);
      drain(16);
      check("satp_0", qc[0], 32'h3FFF0001);
      check("satp_1", qc[1], 32'h7FFE0002);
      check("satp_2", qc[2], 32'h7FFFFFFF);
      check("satp_15", qc[15], 32'h7FFFFFFF);

      // Negative saturation
      do_reset();
      for (int i = 0; i < 16; i++) send(16'h8000, 1'b0);
      drain(16);
      check("satn_0", qc[0], 32'hC0008000);
      check("satn_1", qc[1], 32'h80010000);
      check("satn_2", qc[2], 32'h80000000);
      check("satn_15", qc[15], 32'h80000000);
      check("neg_avg_0", qa[0], 32'hFC000000);
      check("neg_avg_15", qa[15], 32'hC0000000);

      // Two 8-beat impulse frames
      do_reset();
      for (int f = 0; f < 2; f++)
         for (int j = 0; j < 8; j++) send((j == 0) ? 16'd1 : 16'd0, j == 7);
      drain(16);
      for (int i = 0; i < 16; i++) begin
`ifdef FIR_FRAME_FLUSH_EN
         exp_v = 32'd2048;
`else
         exp_v = (i < 8) ? 32'd2048 : 32'd4096;
`endif
         check($sformatf("frame[%0d]", i), qa[i], exp_v);
         check($sformatf("frame_last[%0d]", i), 32'(ql[i]), 32'(i == 7 || i == 15));
      end

      // Random backpressure over a 1024-beat frame versus an unstalled model
      do_reset();
      bp_mode = 1;
      for (int n = 0; n < 1024; n++) begin
         xin[n] = 16'($urandom);
         send(xin[n], n == 1023);
      end
      drain(1024);
      bp_mode = 0;
      for (int n = 0; n < 1024; n++) begin
         acc = 0;
         for (int k = 0; k < 16; k++)
            if (n - k >= 0) acc += longint'(xin[n-k]) * 2048;
         check($sformatf("bp_a[%0d]", n), qa[n], acc[31:0]);
         acc = acc >>> 15;
         check($sformatf("bp_b[%0d]", n), qb[n], acc[31:0]);
         check($sformatf("bp_last[%0d]", n), 32'(ql[n]), 32'(n == 1023));
      end

      // Reset with beats in flight
      do_reset();
      for (int i = 0; i < 3; i++) send(16'd5, 1'b0);
      @(posedge clk); #1;
      check("inflight_valid", 32'(a_valid), 32'd1);
      check("inflight_data", a_data, 32'd10240);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 32'(a_valid), 32'd0);
      check("midrst_data", a_data, 32'd0);
      check("midrst_last", 32'(a_last), 32'd0);
      @(negedge clk);
      qa.delete();
      qb.delete();
      qc.delete();
      ql.delete();
      rst_n = 1'b1;
      @(posedge clk); #1;
      send(16'd1, 1'b1);
      drain(1);
      check("postrst_data", qa[0], 32'd2048);
      check("postrst_last", 32'(ql[0]), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
